// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and datapath:
// ALU operations, SrcB selects, instruction field positions and the ALU itself.
package mips_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int IMM_HI   = 15;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;

   // Unassigned encodings (011, 100, 101) deliberately yield zero.
   function automatic logic [31:0] alu_eval(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0]  ctl);
      logic [31:0] r;
      r = 32'd0;
      case (ctl)
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32 x 32 register file, two combinational read ports, one write port on the
// rising edge; r0 reads as zero and ignores writes, reads return pre-write data.
module mips_regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [32];

   always_ff @(posedge clk) begin
      if (we && (wa != 5'd0))
         regs[wa] <= wd;
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_datapath.sv
// Multicycle MIPS datapath: PC, Instr/Data/A/B/ALUOut, register file, ALU and muxes.
// Steered entirely by the controller's per-cycle control word; no handshaking.
module mips_datapath
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCEn,
   input  logic        IorD,
   input  logic        IRWrite,
   input  logic        MemtoReg,
   input  logic        RegDst,
   input  logic        PCSrc,
   input  logic        ALUSrcA,
   input  logic        RegWrite,
   input  logic [2:0]  ALUControl,
   input  logic [1:0]  ALUSrcB,
   input  logic [31:0] readdata,
   output logic [31:0] adr,
   output logic [31:0] writedata,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic        zero
);

   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] data;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] aluout;

   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] signimm;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic [31:0] aluresult;
   logic [31:0] pcnext;
   logic [31:0] wd3;
   logic [4:0]  wa3;
   logic        rf_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc     <= RESET_PC;
         instr  <= 32'd0;
         data   <= 32'd0;
         a      <= 32'd0;
         b      <= 32'd0;
         aluout <= 32'd0;
      end else begin
         if (PCEn)
            pc <= pcnext;
         if (IRWrite)
            instr <= readdata;
         data   <= readdata;
         a      <= rd1;
         b      <= rd2;
         aluout <= aluresult;
      end
   end

   assign signimm = {{16{instr[IMM_HI]}}, instr[IMM_HI:0]};
   assign wa3     = RegDst ? instr[RD_HI:RD_LO] : instr[RT_HI:RT_LO];
   assign wd3     = MemtoReg ? data : aluout;

   // A write pending while reset is held must not land after the reset edge.
   assign rf_we = RegWrite & ~reset;

   mips_regfile u_rf (
      .clk (clk),
      .we  (rf_we),
      .ra1 (instr[RS_HI:RS_LO]),
      .ra2 (instr[RT_HI:RT_LO]),
      .wa  (wa3),
      .wd  (wd3),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   assign srca = ALUSrcA ? a : pc;

   always_comb begin
      srcb = b;
      case (ALUSrcB)
         SRCB_REG:     srcb = b;
         SRCB_FOUR:    srcb = 32'd4;
         SRCB_IMM:     srcb = signimm;
         SRCB_IMM_SH2: srcb = {signimm[29:0], 2'b00};
         default:      srcb = b;
      endcase
   end

   assign aluresult = alu_eval(srca, srcb, ALUControl);
   assign zero      = (aluresult == 32'd0);
   assign pcnext    = PCSrc ? aluout : aluresult;

   assign adr       = IorD ? aluout : pc;
   assign writedata = b;
   assign op        = instr[OP_HI:OP_LO];
   assign funct     = instr[FUNCT_HI:FUNCT_LO];

endmodule

// File: tb/tb_mips_datapath.sv
// Directed bench for mips_datapath: reset, lw, R-type ALU ops, beq, r0, reset mid-lw.
module tb_mips_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCEn, IorD, IRWrite, MemtoReg, RegDst, PCSrc, ALUSrcA, RegWrite;
   logic [2:0]  ALUControl;
   logic [1:0]  ALUSrcB;
   logic [31:0] readdata;
   logic [31:0] adr, writedata;
   logic [5:0]  op, funct;
   logic        zero;

   int passed = 0;
   int total  = 0;
   int failed = 0;
   logic [31:0] rv;

   always #5 clk = ~clk;

   mips_datapath #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .PCEn       (PCEn),
      .IorD       (IorD),
      .IRWrite    (IRWrite),
      .MemtoReg   (MemtoReg),
      .RegDst     (RegDst),
      .PCSrc      (PCSrc),
      .ALUSrcA    (ALUSrcA),
      .RegWrite   (RegWrite),
      .ALUControl (ALUControl),
      .ALUSrcB    (ALUSrcB),
      .readdata   (readdata),
      .adr        (adr),
      .writedata  (writedata),
      .op         (op),
      .funct      (funct),
      .zero       (zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      PCEn = 0; IorD = 0; IRWrite = 0; MemtoReg = 0; RegDst = 0;
      PCSrc = 0; ALUSrcA = 0; RegWrite = 0; ALUControl = 3'b000; ALUSrcB = 2'b00;
   endtask

   task automatic fetch(input logic [31:0] ins, input logic adv);
      idle();
      readdata = ins; IRWrite = 1; PCEn = adv;
      ALUSrcB = 2'b01; ALUControl = 3'b010;
      tick();
      idle();
   endtask

   // Places a value in register n through the lw writeback path without moving PC.
   task automatic load_reg(input logic [4:0] n, input logic [31:0] val);
      fetch({6'h23, 5'd0, n, 16'd0}, 1'b0);
      readdata = val;
      tick();
      RegWrite = 1; MemtoReg = 1; RegDst = 0;
      tick();
      idle();
   endtask

   // Reads register n through read port 2 into B, observed on writedata.
   task automatic read_reg(input logic [4:0] n, output logic [31:0] v);
      fetch({6'h00, 5'd0, n, 16'd0}, 1'b0);
      tick();
      v = writedata;
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      reset = 0;
      idle();
   endtask

   initial begin
      idle();
      reset = 1;
      readdata = 32'hFFFF_FFFF;
      #3;
      check("rst_adr_pc", adr, 32'h0);
      check("rst_op", {26'd0, op}, 32'h0);
      check("rst_funct", {26'd0, funct}, 32'h0);
      check("rst_writedata", writedata, 32'h0);
      IorD = 1; #1;
      check("rst_aluout", adr, 32'h0);
      idle();
      tick();
      reset = 0;
      tick();
      check("idle_pc_hold", adr, 32'h0);

      // lw $8, 4($0)
      fetch(32'h8C08_0004, 1'b1);
      check("fetch_pc4", adr, 32'h4);
      check("fetch_op", {26'd0, op}, 32'h23);
      tick();
      ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 3'b010;
      tick();
      idle(); IorD = 1; #1;
      check("lw_memadr", adr, 32'h4);
      readdata = 32'h1234_5678;
      tick();
      RegWrite = 1; MemtoReg = 1; RegDst = 0;
      tick();
      idle();
      read_reg(5'd8, rv);
      check("lw_r8", rv, 32'h1234_5678);

      // add $10, $8, $9 with $8 = 5, $9 = 7
      load_reg(5'd8, 32'd5);
      load_reg(5'd9, 32'd7);
      fetch(32'h0109_5020, 1'b0);
      check("add_funct", {26'd0, funct}, 32'h20);
      tick();
      ALUSrcA = 1; ALUSrcB = 2'b00; ALUControl = 3'b010;
      tick();
      idle(); IorD = 1; #1;
      check("add_aluout", adr, 32'd12);
      IorD = 0; RegDst = 1; RegWrite = 1;
      tick();
      idle();
      read_reg(5'd10, rv);
      check("add_r10", rv, 32'd12);

      // slt $10, $8, $9 with $8 = -1, plus the other ALU ops on the same operands
      load_reg(5'd8, 32'hFFFF_FFFF);
      fetch(32'h0109_502A, 1'b0);
      tick();
      ALUSrcA = 1; ALUSrcB = 2'b00; IorD = 1;
      ALUControl = 3'b000; tick();
      check("and_aluout", adr, 32'h0000_0007);
      ALUControl = 3'b001; tick();
      check("or_aluout", adr, 32'hFFFF_FFFF);
      ALUControl = 3'b110; tick();
      check("sub_aluout", adr, 32'hFFFF_FFF8);
      ALUControl = 3'b011; #1;
      check("unused_op_zero", {31'd0, zero}, 32'd1);
      ALUControl = 3'b111; tick();
      check("slt_aluout", adr, 32'd1);
      idle(); RegDst = 1; RegWrite = 1;
      tick();
      idle();
      read_reg(5'd10, rv);
      check("slt_r10", rv, 32'd1);

      // beq $8, $8, +3 taken from PC 0
      do_reset();
      fetch(32'h1108_0003, 1'b1);
      ALUSrcA = 0; ALUSrcB = 2'b11; ALUControl = 3'b010;
      tick();
      idle(); IorD = 1; #1;
      check("beq_target", adr, 32'h10);
      IorD = 0; ALUSrcA = 1; ALUSrcB = 2'b00; ALUControl = 3'b110; PCSrc = 1; #1;
      check("beq_zero_eq", {31'd0, zero}, 32'd1);
      PCEn = zero;
      tick();
      idle();
      check("beq_taken_pc", adr, 32'h10);

      // beq $8, $9, +3 not taken ($8 = -1, $9 = 7)
      do_reset();
      fetch(32'h1109_0003, 1'b1);
      ALUSrcA = 0; ALUSrcB = 2'b11; ALUControl = 3'b010;
      tick();
      idle(); ALUSrcA = 1; ALUSrcB = 2'b00; ALUControl = 3'b110; PCSrc = 1; #1;
      check("beq_zero_ne", {31'd0, zero}, 32'd0);
      PCEn = zero;
      tick();
      idle();
      check("beq_fall_pc", adr, 32'h4);

      // $0 is hardwired
      load_reg(5'd0, 32'hDEAD_BEEF);
      read_reg(5'd0, rv);
      check("r0_zero", rv, 32'h0);

      // lw $8, -4($0), reset asserted during the memory cycle
      fetch(32'h8C08_FFFC, 1'b1);
      tick();
      ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 3'b010;
      tick();
      idle(); IorD = 1; readdata = 32'hCAFE_F00D; #1;
      check("lw_neg_memadr", adr, 32'hFFFF_FFFC);
      reset = 1; #1;
      check("midrst_op", {26'd0, op}, 32'h0);
      check("midrst_aluout", adr, 32'h0);
      IorD = 0; #1;
      check("midrst_pc", adr, 32'h0);
      RegWrite = 1; MemtoReg = 1;
      tick();
      reset = 0;
      idle();
      read_reg(5'd8, rv);
      check("midrst_r8_kept", rv, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mips_datapath.md
# mips_datapath

Multicycle MIPS datapath: the block that consumes the control word produced by the multicycle controller and returns `op`, `funct` and `zero` to it. Holds the PC, the non-architectural registers (Instr, Data, A, B, ALUOut), the register file, the ALU and the operand/result muxes. Drives the unified instruction/data memory address and write data; `MemWrite` goes from the controller straight to memory and does not pass through this block.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PCEn`  in  1  PC load enable, already combined as (branch & zero) | PCWrite.
- `IorD`  in  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  in  1  Instr register load enable.
- `MemtoReg`  in  1  register-file write data: 0 = ALUOut, 1 = Data.
- `RegDst`  in  1  write register: 0 = Instr[20:16], 1 = Instr[15:11].
- `PCSrc`  in  1  next PC: 0 = ALUResult, 1 = ALUOut.
- `ALUSrcA`  in  1  SrcA: 0 = PC, 1 = A.
- `RegWrite`  in  1  register-file write enable.
- `ALUControl`  in  3  ALU operation.
- `ALUSrcB`  in  2  SrcB: 00 = B, 01 = 32'd4, 10 = SignImm, 11 = SignImm << 2.
- `readdata`  in  32  memory read data, combinational with `adr`.
- `adr`  out  32  memory address.
- `writedata`  out  32  memory write data (= B register).
- `op`  out  6  Instr[31:26].
- `funct`  out  6  Instr[5:0].
- `zero`  out  1  ALUResult == 0 (combinational).

## Operation
- Registers: PC (enable `PCEn`), Instr (enable `IRWrite`), Data, A, B, ALUOut (no enable; load every edge).
- A/B load register-file read ports 1/2, addressed by Instr[25:21] / Instr[20:16].
- SignImm = {{16{Instr[15]}}, Instr[15:0]}.
- ALU `ALUControl`: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed; result 1 or 0); 011, 100, 101 give 0. Add/sub wrap modulo 2^32, no overflow flag.
- Register file: 32 x 32, two combinational read ports, one write port on the rising edge when `RegWrite`. Register 0 always reads 0; writes to it are discarded. Read-during-write of the same register returns the old value.
- `adr`, `zero`, `op`, `funct` are combinational from register state and inputs.

## Timing
- Reset (async assert, state held while high): PC = `RESET_PC`; Instr, Data, A, B, ALUOut = 0; therefore `op` = 0, `funct` = 0, `writedata` = 0, `adr` = `RESET_PC` when `IorD` = 0. Register-file contents are not reset.
- First rising edge after `reset` deasserts performs normal updates.
- Fetch cycle (PCEn, IRWrite, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, add, PCSrc = 0): on the edge, Instr <= readdata and PC <= PC + 4 together; the Instr load uses the pre-edge PC address.
- Decode: A/B valid one edge after Instr loads. ALUOut valid one edge after the ALU cycle. Data valid one edge after the memory read cycle.
- Branch target: computed into ALUOut during decode (ALUSrcB = 11, SrcA = PC+4); taken in the compare cycle with PCSrc = 1 when `PCEn` is high.
- Simultaneous `PCEn` and `IRWrite` is legal; both use pre-edge values.
- Reset mid-instruction aborts it; no partial register-file write completes after the reset edge.

## Structure
- Shared package `mips_pkg`: ALUControl encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), ALUSrcB encodings, opcode field positions. The controller's ALU decoder uses the same constants.
- One sub-module: `mips_regfile` (32 x 32, 2R1W, r0 hardwired). ALU and muxes stay inline.

## Test plan
- Reset with `readdata` = 32'hFFFF_FFFF -> PC = 0, `adr` = 0, `op` = 0, `funct` = 0, `writedata` = 0; release reset, no enables -> PC stays 0.
- Fetch with `readdata` = 32'h8C08_0004 (lw $8, 4($0)) -> next edge PC = 4, `op` = 6'h23; after the memory cycle with `readdata` = 32'h1234_5678, MemtoReg = 1, RegDst = 0, RegWrite -> $8 reads 32'h1234_5678.
- add $10, $8, $9 with $8 = 5, $9 = 7 -> ALUOut = 12, $10 = 12; same registers with slt and $8 = -1 -> $10 = 1.
- beq $8, $8, +3 at PC 0 -> decode ALUOut = 32'h10, compare `zero` = 1, PC = 32'h10 with PCSrc = 1; with unequal operands `zero` = 0 and PC stays 4.
- Write $0 with 32'hDEAD_BEEF -> reads of $0 return 0.
- Assert reset during the memory cycle of lw -> Instr and ALUOut clear immediately, PC = `RESET_PC`, destination register unchanged.
